// File: rtl/vector_log_reader.sv
// vector_log_reader
//
// Parses response-log text, one line per vector:
//   <IN_W chars of 0/1> ' ' <OUT_W chars of 0/1/x/X/z/Z> '\n'
// and emits each well-formed line as a record {stimulus, response, X/Z mask}.
// Malformed lines are reported, dropped, and the parser resynchronises on
// the next newline. Carriage returns are ignored everywhere.
//
// Handshakes (both sides): a transfer happens on a rising CK edge where
// valid & ready are both high. A producer holds valid and its payload stable
// until that transfer. s_ready is low only while a finished record sits in the
// output register and the consumer is not taking it this cycle.
//
// Ports
//   CK          clock
//   reset       asynchronous, active-low reset
//   s_valid     byte stream valid
//   s_ready     byte stream ready
//   s_data      ASCII byte
//   m_valid     record valid
//   m_ready     record accepted by downstream
//   m_in_vec    stimulus vector (first char = MSB)
//   m_out_vec   response vector, X/Z positions read 0
//   m_out_xmask 1 where the response char was x/X/z/Z
//   m_index     record sequence number, wraps 255 -> 0
//   err_pulse   one-cycle pulse per rejected line
//   err_code    cause of last rejection: 1 = bad char, 2 = bad length/field
//   err_count   saturating count of rejected lines
//   dbg_state   current parser state (0 = S_IN, 1 = S_OUT, 2 = S_SKIP)
module vector_log_reader #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IN_W-1:0]  m_in_vec,
    output logic [OUT_W-1:0] m_out_vec,
    output logic [OUT_W-1:0] m_out_xmask,
    output logic [7:0]       m_index,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [7:0]       err_count,
    output logic [1:0]       dbg_state
);

    localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);

    typedef enum logic [1:0] {
        S_IN   = 2'd0,
        S_OUT  = 2'd1,
        S_SKIP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IN_W-1:0]    in_shift;
    logic [OUT_W-1:0]   out_shift;
    logic [OUT_W-1:0]   xmask_shift;

    logic acc;
    logic is_cr, is_nl, is_sp, is_digit, is_xz;
    logic shift_in_en, shift_out_en, out_bit, x_bit;
    logic complete, err_now;
    logic [1:0] err_code_nxt;

    assign acc      = s_valid & s_ready;
    assign is_cr    = (s_data == 8'h0D);
    assign is_nl    = (s_data == 8'h0A);
    assign is_sp    = (s_data == 8'h20);
    assign is_digit = (s_data == 8'h30) || (s_data == 8'h31);
    assign is_xz    = (s_data == 8'h78) || (s_data == 8'h58) ||
                      (s_data == 8'h7A) || (s_data == 8'h5A);

    // State register
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= S_IN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and per-byte decode
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shift_in_en  = 1'b0;
        shift_out_en = 1'b0;
        out_bit      = 1'b0;
        x_bit        = 1'b0;
        complete     = 1'b0;
        err_now      = 1'b0;
        err_code_nxt = 2'd0;

        if (acc && !is_cr) begin
            case (state)
                S_IN: begin
                    if (is_digit) begin
                        if (cnt == IN_CNT) begin
                            err_now      = 1'b1;
                            err_code_nxt = 2'd2;
                        end else begin
                            shift_in_en = 1'b1;
                            cnt_nxt     = cnt + 1'b1;
                        end
                    end else if (is_sp) begin
                        if (cnt == IN_CNT) begin
                            state_nxt = S_OUT;
                            cnt_nxt   = '0;
                        end else begin
                            err_now      = 1'b1;
                            err_code_nxt = 2'd2;
                        end
                    end else if (is_nl) begin
                        // An empty line is not an error.
                        if (cnt != '0) begin
                            err_now      = 1'b1;
                            err_code_nxt = 2'd2;
                        end
                    end else begin
                        err_now      = 1'b1;
                        err_code_nxt = 2'd1;
                    end
                end
                S_OUT: begin
                    if (is_digit || is_xz) begin
                        if (cnt == OUT_CNT) begin
                            err_now      = 1'b1;
                            err_code_nxt = 2'd2;
                        end else begin
                            shift_out_en = 1'b1;
                            out_bit      = is_digit & s_data[0];
                            x_bit        = is_xz;
                            cnt_nxt      = cnt + 1'b1;
                        end
                    end else if (is_nl) begin
                        if (cnt == OUT_CNT) begin
                            complete  = 1'b1;
                            state_nxt = S_IN;
                            cnt_nxt   = '0;
                        end else begin
                            err_now      = 1'b1;
                            err_code_nxt = 2'd2;
                        end
                    end else if (is_sp) begin
                        err_now      = 1'b1;
                        err_code_nxt = 2'd2;
                    end else begin
                        err_now      = 1'b1;
                        err_code_nxt = 2'd1;
                    end
                end
                S_SKIP: begin
                    if (is_nl) begin
                        state_nxt = S_IN;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IN;
                    cnt_nxt   = '0;
                end
            endcase

            // A rejected newline already ends the line, so no skipping needed.
            if (err_now) begin
                state_nxt = is_nl ? S_IN : S_SKIP;
                cnt_nxt   = '0;
            end
        end
    end

    // Combinational outputs
    always_comb begin
        s_ready   = !(m_valid && !m_ready);
        dbg_state = state;
    end

    // Field shift registers. Every accepted line shifts exactly IN_W / OUT_W
    // times, so stale bits from an earlier line are always overwritten.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            in_shift    <= '0;
            out_shift   <= '0;
            xmask_shift <= '0;
        end else begin
            if (shift_in_en) begin
                in_shift <= (in_shift << 1) | IN_W'(s_data[0]);
            end
            if (shift_out_en) begin
                out_shift   <= (out_shift << 1) | OUT_W'(out_bit);
                xmask_shift <= (xmask_shift << 1) | OUT_W'(x_bit);
            end
        end
    end

    // Record output register. A completion can only occur while s_ready is
    // high, i.e. the slot is empty or being emptied this same cycle.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            m_valid     <= 1'b0;
            m_in_vec    <= '0;
            m_out_vec   <= '0;
            m_out_xmask <= '0;
            m_index     <= '0;
        end else begin
            if (complete) begin
                m_valid     <= 1'b1;
                m_in_vec    <= in_shift;
                m_out_vec   <= out_shift;
                m_out_xmask <= xmask_shift;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (m_valid && m_ready) begin
                m_index <= m_index + 8'd1;
            end
        end
    end

    // Error reporting
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= err_now;
            if (err_now) begin
                err_code <= err_code_nxt;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_log_reader.sv
module tb_vector_log_reader;

    localparam int IN_W  = 3;
    localparam int OUT_W = 1;
    localparam int REC_W = 8 + IN_W + 2 * OUT_W;

    logic             CK = 1'b0;
    logic             reset = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       s_data = 8'h00;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [IN_W-1:0]  m_in_vec;
    logic [OUT_W-1:0] m_out_vec;
    logic [OUT_W-1:0] m_out_xmask;
    logic [7:0]       m_index;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic [7:0]       err_count;
    logic [1:0]       dbg_state;

    vector_log_reader #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .CK          (CK),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_in_vec    (m_in_vec),
        .m_out_vec   (m_out_vec),
        .m_out_xmask (m_out_xmask),
        .m_index     (m_index),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CK = ~CK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [REC_W-1:0] exp_q[$];   // {index, in, out, xmask}
    logic [9:0]       err_q[$];   // {code, count}
    int ready_mode = 1;           // 0: m_ready low, 1: high, 2: random

    // reference model: text of the current line and running totals
    byte line_q[$];
    bit  m_skip = 1'b0;
    int  m_idx  = 0;
    int  m_errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    function automatic bit is_dig(input byte b);
        return (b == 8'h30) || (b == 8'h31);
    endfunction

    function automatic bit is_xz(input byte b);
        return (b == 8'h78) || (b == 8'h58) || (b == 8'h7A) || (b == 8'h5A);
    endfunction

    function automatic void model_err(input int code);
        if (m_errs < 255) m_errs++;
        err_q.push_back({2'(code), 8'(m_errs)});
    endfunction

    // A line is: IN_W digits, a space, OUT_W digit/x/z chars, newline.
    // The first character that does not fit its column rejects the line;
    // it is a "bad char" unless it is one of the field alphabet for that side.
    function automatic void model_byte(input byte b);
        int pos;
        bit ok;
        bit legal;
        logic [IN_W-1:0]  iv;
        logic [OUT_W-1:0] ov, xv;
        if (b == 8'h0D) return;
        if (m_skip) begin
            if (b == 8'h0A) begin
                m_skip = 1'b0;
                line_q.delete();
            end
            return;
        end
        pos = line_q.size();
        if (b == 8'h0A) begin
            if (pos == IN_W + OUT_W + 1) begin
                iv = '0; ov = '0; xv = '0;
                for (int i = 0; i < IN_W; i++) iv = (iv << 1) | IN_W'(line_q[i][0]);
                for (int j = 0; j < OUT_W; j++) begin
                    byte c;
                    c  = line_q[IN_W + 1 + j];
                    ov = (ov << 1) | OUT_W'(is_xz(c) ? 1'b0 : c[0]);
                    xv = (xv << 1) | OUT_W'(is_xz(c));
                end
                exp_q.push_back({8'(m_idx), iv, ov, xv});
                m_idx = (m_idx + 1) % 256;
            end else if (pos != 0) begin
                model_err(2);
            end
            line_q.delete();
            return;
        end
        if (pos < IN_W)                ok = is_dig(b);
        else if (pos == IN_W)          ok = (b == 8'h20);
        else if (pos <= IN_W + OUT_W)  ok = is_dig(b) || is_xz(b);
        else                           ok = 1'b0;
        if (ok) begin
            line_q.push_back(b);
        end else begin
            if (pos <= IN_W) legal = is_dig(b) || (b == 8'h20);
            else             legal = is_dig(b) || is_xz(b) || (b == 8'h20);
            model_err(legal ? 2 : 1);
            m_skip = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        line_q.delete();
        exp_q.delete();
        err_q.delete();
        m_skip = 1'b0;
        m_idx  = 0;
        m_errs = 0;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input byte b);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        forever begin
            @(negedge CK);
            acc = s_ready;
            @(posedge CK);
            #1;
            if (acc) break;
            n++;
            if (n > 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_accept: byte %0h not taken, got s_ready=0 expected 1", b);
                break;
            end
        end
        s_valid = 1'b0;
        if (acc) model_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 1;
        cyc(3);
        while ((exp_q.size() != 0 || err_q.size() != 0) && n < 500) begin
            cyc(1);
            n++;
        end
        chk("drain_records_left", exp_q.size(), 0);
        chk("drain_errors_left", err_q.size(), 0);
    endtask

    // m_ready generator (sole driver of m_ready)
    initial begin
        forever begin
            @(posedge CK);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [REC_W-1:0] e;
        logic [9:0]       ee;
        forever begin
            @(negedge CK);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rec_unexpected: got in=%0b out=%0b idx=%0d expected no record",
                             m_in_vec, m_out_vec, m_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("rec_index", m_index, e[REC_W-1 -: 8]);
                    chk("rec_in_vec", m_in_vec, e[2*OUT_W +: IN_W]);
                    chk("rec_out_vec", m_out_vec, e[OUT_W +: OUT_W]);
                    chk("rec_xmask", m_out_xmask, e[0 +: OUT_W]);
                end
            end
            if (err_pulse) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL err_unexpected: got err_pulse=1 code=%0d expected 0", err_code);
                end else begin
                    ee = err_q.pop_front();
                    chk("err_code", err_code, ee[9:8]);
                    chk("err_count", err_count, ee[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs(input string tag);
        @(negedge CK);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_m_in_vec"}, m_in_vec, 0);
        chk({tag, "_m_out_vec"}, m_out_vec, 0);
        chk({tag, "_m_xmask"}, m_out_xmask, 0);
        chk({tag, "_m_index"}, m_index, 0);
        chk({tag, "_err_pulse"}, err_pulse, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        byte cs[8];
        byte ln[$];
        int base_idx;
        int n;
        cs = '{8'h30, 8'h31, 8'h78, 8'h20, 8'h61, 8'h23, 8'h5A, 8'h0A};

        // reset
        reset = 1'b0;
        ready_mode = 1;
        check_reset_outputs("por");
        cyc(2);
        reset = 1'b1;
        cyc(2);

        // single record
        send_str("101 1\n");
        drain();
        chk("single_err_count", err_count, m_errs);

        // eight lines, in order
        for (int v = 0; v < 8; v++) begin
            send_byte(v[2] ? 8'h31 : 8'h30);
            send_byte(v[1] ? 8'h31 : 8'h30);
            send_byte(v[0] ? 8'h31 : 8'h30);
            send_byte(8'h20);
            send_byte(v[0] ? 8'h31 : 8'h30);
            send_byte(8'h0A);
        end
        drain();

        // short input field, then an x response
        send_str("01 1\n011 x\n");
        drain();
        chk("short_err_code", err_code, 2);
        chk("short_err_count", err_count, m_errs);

        // bad character, skip to newline, then recover
        send_str("1a1 0\n110 1\n");
        drain();
        chk("badchar_err_code", err_code, 1);
        chk("badchar_err_count", err_count, m_errs);

        // back-pressure: first record held, parser stalls, nothing lost
        ready_mode = 0;
        cyc(2);
        base_idx = m_idx;
        fork
            send_str("001 1\n010 0\n");
            begin
                n = 0;
                while (!m_valid && n < 200) begin
                    cyc(1);
                    n++;
                end
                chk("stall_m_valid", m_valid, 1);
                for (int k = 0; k < 4; k++) begin
                    @(negedge CK);
                    chk("stall_s_ready", s_ready, 0);
                    chk("stall_hold_in", m_in_vec, 3'b001);
                    chk("stall_hold_idx", m_index, 8'(base_idx));
                end
                @(posedge CK);
                #1;
                ready_mode = 1;
            end
        join
        drain();

        // reset in the middle of a line
        send_str("10");
        reset = 1'b0;
        model_reset();
        check_reset_outputs("midline");
        cyc(2);
        reset = 1'b1;
        cyc(2);
        send_str("100 1\r\n");
        drain();

        // randomized lines with random downstream back-pressure
        ready_mode = 2;
        for (int l = 0; l < 150; l++) begin
            int r;
            ln.delete();
            r = $urandom_range(0, 9);
            if (r != 0) begin
                for (int i = 0; i < IN_W; i++) ln.push_back($urandom_range(0, 1) ? 8'h31 : 8'h30);
                ln.push_back(8'h20);
                for (int j = 0; j < OUT_W; j++) ln.push_back(cs[$urandom_range(0, 2)]);
            end
            if ($urandom_range(0, 4) == 0) ln.push_back(8'h0D);
            ln.push_back(8'h0A);
            if (r >= 7) begin
                int p;
                int op;
                byte ch;
                p  = $urandom_range(0, ln.size() - 2);
                op = $urandom_range(0, 2);
                ch = cs[$urandom_range(0, 7)];
                if (op == 0)      ln[p] = ch;
                else if (op == 1) ln.insert(p, ch);
                else              ln.delete(p);
            end
            foreach (ln[i]) send_byte(ln[i]);
            if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
        end
        drain();
        chk("final_err_count", err_count, m_errs);
        chk("final_index", m_index, 8'(m_idx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
